// File: rtl/mux_out_collector_pkg.sv
// Shared sizing and types for the mux output collector and its per-channel FIFOs.
package mux_out_pkg;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;

  typedef logic [$clog2(NUM_CH)-1:0] chan_t;
  typedef logic [DATA_W-1:0]         data_t;
  typedef logic [$clog2(DEPTH):0]    cnt_t;

endpackage

// File: rtl/mux_out_collector_chan_fifo.sv
// One synchronous FIFO per channel. The head entry is kept in its own register so
// the consumer sees a registered output with one cycle of latency after a push.
module chan_fifo
  import mux_out_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  data_t push_data,
  output data_t head,
  output logic  valid,
  output cnt_t  count,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  data_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic             do_push;
  logic             do_pop;
  cnt_t             count_next;

  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + 1'b1;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count, valid and head register. The head reloads on a pop from the next
  // slot, or from the incoming beat when that beat becomes the new head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      count <= count_next;
      valid <= (count_next != '0);
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
        if (count > cnt_t'(1)) begin
          head <= mem[rd_next];
        end else if (do_push) begin
          head <= push_data;
        end
      end else if (do_push && empty) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/mux_out_collector.sv
// Captures each valid mux beat into the FIFO of its channel, drains every channel
// through its own valid/ready port, and keeps a sticky overflow flag per channel.
module mux_out_collector
  import mux_out_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  chan_t                    in_chan,
  input  data_t                    in_data0,
  input  data_t                    in_data1,
  input  data_t                    in_data2,
  input  data_t                    in_data3,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*3-1:0]      count,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     ovf_clr
);

  data_t             sel_data;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;

  // Pick the data lane named by the beat's channel; the other lanes are ignored.
  always_comb begin
    sel_data = in_data0;
    case (in_chan)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = in_valid && (in_chan == chan_t'(i));
    assign pop[i]  = out_ready[i] && !empty[i];

    chan_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data (sel_data),
      .head      (out_data[i*DATA_W +: DATA_W]),
      .valid     (out_valid[i]),
      .count     (count[i*3 +: 3]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // Sticky overflow: a push into a full FIFO with no pop sets the bit, and a set
  // in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i] && full[i] && !pop[i]) begin
          ovf[i] <= 1'b1;
        end else if (ovf_clr) begin
          ovf[i] <= 1'b0;
        end
      end
    end
  end

endmodule
